mux8_rr_scheduler: RTL
======================

Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares the 8-to-1 bit multiplexer between 8 requesters.
- Arbitrates `req[7:0]` and drives the mux select `sel[2:0]`, plus a one-hot grant back to each requester.
- A granted requester may keep the mux for a bounded burst of cycles, so no source can starve the others.
- Sits directly in front of the mux select input; the mux data path is unchanged.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles per owner while others are waiting; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per source; bit i asks for mux input d[i].
- gnt  output  8  registered one-hot grant; all zero when idle.
- sel  output  3  registered binary index of the granted source; connects to mux select.
- gnt_valid  output  1  registered; high when `gnt` holds a valid owner.

Behaviour:
- Reset: `rst_n` low clears everything immediately, without waiting for a clock edge.
  - gnt=0, sel=0, gnt_valid=0.
  - Internal: state=IDLE, ptr=0, hold_cnt=0.
  - This applies mid-burst too: the grant drops at once.
- Priority pointer `ptr[2:0]`:
  - The search order is ptr, ptr+1, … ptr+7, wrapping modulo 8.
  - The first set request bit in that order wins.
  - On every new grant to source k, ptr is set to k+1 mod 8 (7 wraps to 0).
- States: IDLE and GRANT.
- IDLE:
  - If req≠0 at a rising edge: grant the winner at that edge. Set gnt=1<<k, sel=k, gnt_valid=1, hold_cnt=1, state goes to GRANT.
  - Latency is one cycle from req sampled to gnt visible.
  - If req=0: stay in IDLE, outputs stay zero.
- GRANT, owner k, evaluated at each edge:
  - Release: if req[k]=0 and another request is pending, re-arbitrate among the others that same edge. There is no idle bubble. The new owner is granted, hold_cnt=1.
  - Release with nothing pending: if req[k]=0 and req=0, go to IDLE and clear gnt, sel and gnt_valid.
  - Burst expiry: if req[k]=1, hold_cnt==MAX_HOLD and (req & ~gnt)≠0, force rotation to the winner among the other sources, hold_cnt=1.
  - An expiring owner is not eligible at the rotation edge. Because ptr=k+1, it is naturally lowest priority.
  - Continue: if req[k]=1 and no expiry, keep the grant. hold_cnt increments, saturating at MAX_HOLD.
  - No competitor: with req[k]=1 and no other requests, the owner keeps the grant indefinitely and hold_cnt stays at MAX_HOLD.
  - A competitor arriving later causes rotation at the next edge.
- Guarantees:
  - An owner with competitors receives exactly MAX_HOLD consecutive gnt_valid cycles, unless it drops req earlier.
  - `gnt` is always one-hot or zero.
  - sel always equals the index of the set gnt bit; sel=0 while idle.
  - gnt_valid equals |gnt.
- Request rules:
  - Requests are level-sensitive. A requester deasserting while not granted loses no state.
  - Simultaneous edges: release/expiry and new requests are evaluated together at the same edge using the current ptr.
- All outputs are registered; there is no combinational path from req to outputs.

Test Plan:
- Reset: hold rst_n=0 with req=0xFF → gnt=0x00, sel=0, gnt_valid=0. Release reset → first grant at the next edge is gnt=0x01, sel=0.
- Single requester: req=0x20 from cycle 0 to cycle 5, then 0 → gnt=0x20, sel=5 from edge 1 while req is held. gnt_valid falls at the edge after req drops.
- Full load: req=0xFF constant, MAX_HOLD=4 → sel sequence 0,0,0,0,1,1,1,1,…,7,7,7,7,0. Wrap from 7 to 0 is verified and gnt stays one-hot throughout.
- Release skip: owner 3, req=0x44 when req[3] drops → next edge gnt=0x40, sel=6 (search starts at 4). gnt_valid stays 1, with no bubble cycle.
- Lone owner: req=0x08 held for 12 cycles → gnt=0x08 every cycle, no drop at hold expiry. Raise req[0] at cycle 12 → gnt=0x01 at the following edge.
- Async reset mid-burst: owner 6 with hold_cnt=2, pull rst_n low between edges → outputs go to zero before the next edge. After release with req=0x41, the grant goes to source 0 because ptr was reset to 0.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler for an 8:1 bit mux: registered one-hot grant and select,
// with a bounded burst per owner whenever other sources are waiting.
module mux8_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid
);

    localparam int unsigned N_SRC = 8;
    localparam int unsigned SEL_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [N_SRC-1:0] arb_mask_c;
    logic             arb_found_c;
    logic [SEL_W-1:0] arb_idx_c;
    logic [SEL_W-1:0] cand_c;
    logic             owner_req_c;
    logic             expire_c;

    // The current owner is never a candidate: on release its bit is already low, on expiry it must yield.
    assign arb_mask_c  = req & ~gnt_q;
    assign owner_req_c = |(req & gnt_q);
    assign expire_c    = (hold_cnt_q == CNT_W'(MAX_HOLD));

    // First set candidate searching ptr, ptr+1, ... wrapping modulo 8.
    always_comb begin
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        cand_c      = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            cand_c = ptr_q + SEL_W'(i);
            if (!arb_found_c && arb_mask_c[cand_c]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = cand_c;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        gnt_valid_d = gnt_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_found_c) begin
                    state_d     = ST_GRANT;
                    gnt_d       = N_SRC'(1) << arb_idx_c;
                    sel_d       = arb_idx_c;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    ptr_d       = arb_idx_c + SEL_W'(1);
                end
            end
            ST_GRANT: begin
                if ((!owner_req_c || expire_c) && arb_found_c) begin
                    gnt_d       = N_SRC'(1) << arb_idx_c;
                    sel_d       = arb_idx_c;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    ptr_d       = arb_idx_c + SEL_W'(1);
                end else if (!owner_req_c) begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    sel_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end else if (!expire_c) begin
                    hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                sel_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;

endmodule
